// File: rtl/enc_gen_pkg.sv
// rtl/enc_gen_pkg.sv - shared state type, field constants and word packing for enc_pattern_gen
package enc_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } gen_state_e;

    localparam int ENC_ANG_MSB = 51;
    localparam int ENC_ANG_LSB = 34;
    localparam int ENC_LIN_W   = 34;
    localparam int ENC_ANG_W   = ENC_ANG_MSB - ENC_ANG_LSB + 1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [63:0] pack_word(
        input logic [ENC_ANG_W-1:0] ang,
        input logic [ENC_LIN_W-1:0] lin
    );
        logic [63:0] w;
        w = '0;
        w[ENC_ANG_MSB:ENC_ANG_LSB] = ang;
        w[ENC_LIN_W-1:0]           = lin;
        return w;
    endfunction

endpackage

// File: rtl/enc_gen_lfsr.sv
// rtl/enc_gen_lfsr.sv - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) supplying the angle jitter bit
module enc_gen_lfsr
    import enc_gen_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic soft_rst_sync,
    input  logic load,
    input  logic adv,
    output logic jit
);

    logic [15:0] lfsr_q;
    logic        fb;

    assign fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign jit = lfsr_q[0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (soft_rst_sync || load) begin
            lfsr_q <= LFSR_SEED;
        end else if (adv) begin
            lfsr_q <= {lfsr_q[14:0], fb};
        end
    end

endmodule

// File: rtl/enc_pattern_gen.sv
// rtl/enc_pattern_gen.sv - synthetic wafer encoder word generator; ENC_GEN_JITTER_EN adds LFSR angle jitter
module enc_pattern_gen
    import enc_gen_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 soft_rst_sync,
    input  logic                 gen_en,
    input  logic [ENC_ANG_W-1:0] cfg_start_ang,
    input  logic [ENC_ANG_W-1:0] cfg_ang_step,
    input  logic [ENC_ANG_W-1:0] cfg_rev_max,
    input  logic [15:0]          cfg_interval,
    input  logic [ENC_LIN_W-1:0] cfg_lin_step,
    input  logic [15:0]          cfg_track_total,
    output logic [63:0]          enc_dout,
    output logic                 enc_dout_vld,
    output logic [15:0]          track_cnt,
    output logic                 gen_busy,
    output logic                 gen_done,
    output logic                 cfg_err
);

    gen_state_e             state;
    logic [ENC_ANG_W-1:0]   angle;
    logic [ENC_ANG_W-1:0]   step_q;
    logic [ENC_ANG_W-1:0]   rev_q;
    logic [ENC_LIN_W-1:0]   linear;
    logic [ENC_LIN_W-1:0]   lin_q;
    logic [15:0]            ivl_q;
    logic [15:0]            total_q;
    logic [15:0]            ivl_cnt;
    logic [63:0]            dout_q;

    logic [ENC_ANG_W:0]     step_eff;
    logic [ENC_ANG_W:0]     chk_step;
    logic [ENC_ANG_W:0]     sum;
    logic [ENC_ANG_W-1:0]   angle_nxt;
    logic [15:0]            ivl_reload;
    logic                   wrap;
    logic                   fire;
    logic                   hit;
    logic                   cfg_bad;

`ifdef ENC_GEN_JITTER_EN
    logic jit;

    enc_gen_lfsr u_lfsr (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .soft_rst_sync (soft_rst_sync),
        .load          (state == ST_LOAD),
        .adv           (fire),
        .jit           (jit)
    );

    // Jitter can add one count, so legality is judged against the worst-case step.
    assign step_eff = {1'b0, step_q} + {{ENC_ANG_W{1'b0}}, jit};
    assign chk_step = {1'b0, cfg_ang_step} + 1'b1;
`else
    assign step_eff = {1'b0, step_q};
    assign chk_step = {1'b0, cfg_ang_step};
`endif

    assign cfg_bad = (cfg_rev_max == '0) || (chk_step == '0) ||
                     (chk_step >= {1'b0, cfg_rev_max}) || (cfg_start_ang >= cfg_rev_max);

    // Legal steps are below rev_max, so one subtraction always lands back in range.
    assign sum        = {1'b0, angle} + step_eff;
    assign wrap       = (sum >= {1'b0, rev_q});
    assign angle_nxt  = wrap ? ENC_ANG_W'(sum - {1'b0, rev_q}) : sum[ENC_ANG_W-1:0];
    assign ivl_reload = (ivl_q == 16'd0) ? 16'd0 : ivl_q - 16'd1;

    // The stop condition is the emitted word already carrying the target track count.
    assign fire = (state == ST_RUN) && gen_en && (ivl_cnt == 16'd0);
    assign hit  = fire && (total_q != 16'd0) && (track_cnt == total_q);

    assign enc_dout_vld = fire;
    assign enc_dout     = fire ? pack_word(angle, linear) : dout_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            angle     <= '0;
            linear    <= '0;
            track_cnt <= '0;
            dout_q    <= '0;
            ivl_cnt   <= '0;
            step_q    <= '0;
            rev_q     <= '0;
            lin_q     <= '0;
            ivl_q     <= '0;
            total_q   <= '0;
            gen_busy  <= 1'b0;
            gen_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (soft_rst_sync) begin
            state     <= ST_IDLE;
            angle     <= '0;
            linear    <= '0;
            track_cnt <= '0;
            dout_q    <= '0;
            ivl_cnt   <= '0;
            step_q    <= '0;
            rev_q     <= '0;
            lin_q     <= '0;
            ivl_q     <= '0;
            total_q   <= '0;
            gen_busy  <= 1'b0;
            gen_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gen_en) begin
                        state    <= ST_LOAD;
                        gen_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    step_q    <= cfg_ang_step;
                    rev_q     <= cfg_rev_max;
                    lin_q     <= cfg_lin_step;
                    ivl_q     <= cfg_interval;
                    total_q   <= cfg_track_total;
                    angle     <= cfg_start_ang;
                    linear    <= '0;
                    track_cnt <= '0;
                    ivl_cnt   <= '0;
                    if (cfg_bad) begin
                        cfg_err  <= 1'b1;
                        gen_busy <= 1'b0;
                        gen_done <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cfg_err  <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        dout_q  <= pack_word(angle, linear);
                        ivl_cnt <= ivl_reload;
                        angle   <= angle_nxt;
                        if (wrap) begin
                            track_cnt <= track_cnt + 16'd1;
                            linear    <= linear + lin_q;
                        end
                    end else if (ivl_cnt != 16'd0) begin
                        ivl_cnt <= ivl_cnt - 16'd1;
                    end
                    if (hit) begin
                        state    <= ST_DONE;
                        gen_busy <= 1'b0;
                        gen_done <= 1'b1;
                    end else if (!gen_en) begin
                        state    <= ST_IDLE;
                        gen_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!gen_en) begin
                        state    <= ST_IDLE;
                        gen_done <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gen_busy <= 1'b0;
                    gen_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_pattern_gen.sv
// tb/tb_enc_pattern_gen.sv - scoreboard bench for enc_pattern_gen
`timescale 1ns/1ps
module tb_enc_pattern_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        soft_rst_sync = 1'b0;
    logic        gen_en = 1'b0;
    logic [17:0] cfg_start_ang = '0;
    logic [17:0] cfg_ang_step = '0;
    logic [17:0] cfg_rev_max = '0;
    logic [15:0] cfg_interval = '0;
    logic [33:0] cfg_lin_step = '0;
    logic [15:0] cfg_track_total = '0;
    logic [63:0] enc_dout;
    logic        enc_dout_vld;
    logic [15:0] track_cnt;
    logic        gen_busy;
    logic        gen_done;
    logic        cfg_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] word;
        int          cyc;
        logic [15:0] trk;
    } obs_t;

    obs_t        obs_q[$];
    logic [63:0] exp_q[$];
    int          jit_a[2][40];

    enc_pattern_gen dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .soft_rst_sync   (soft_rst_sync),
        .gen_en          (gen_en),
        .cfg_start_ang   (cfg_start_ang),
        .cfg_ang_step    (cfg_ang_step),
        .cfg_rev_max     (cfg_rev_max),
        .cfg_interval    (cfg_interval),
        .cfg_lin_step    (cfg_lin_step),
        .cfg_track_total (cfg_track_total),
        .enc_dout        (enc_dout),
        .enc_dout_vld    (enc_dout_vld),
        .track_cnt       (track_cnt),
        .gen_busy        (gen_busy),
        .gen_done        (gen_done),
        .cfg_err         (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (enc_dout_vld === 1'b1) begin
            obs_t o;
            o.word = enc_dout;
            o.cyc  = cyc;
            o.trk  = track_cnt;
            obs_q.push_back(o);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cfg(input int start, input int step, input int rev, input int ivl,
                           input logic [33:0] lin, input int total);
        cfg_start_ang   = 18'(start);
        cfg_ang_step    = 18'(step);
        cfg_rev_max     = 18'(rev);
        cfg_interval    = 16'(ivl);
        cfg_lin_step    = lin;
        cfg_track_total = 16'(total);
    endtask

    task automatic model(input int start, input int step, input int rev,
                         input logic [33:0] lin_step, input int total, input int n);
        int          ang;
        int          trk;
        logic [33:0] lin;
        ang = start;
        trk = 0;
        lin = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({12'd0, 18'(ang), lin});
            if (total != 0 && trk == total) break;
            if (ang + step >= rev) begin
                ang = ang + step - rev;
                trk = trk + 1;
                lin = lin + lin_step;
            end else begin
                ang = ang + step;
            end
        end
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge sys_clk);
            if (obs_q.size() >= n) break;
        end
        #1;
        if (i == budget) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: got %0d strobes required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++;
        if ({enc_dout, enc_dout_vld, track_cnt, gen_busy, gen_done, cfg_err} !== '0) begin
            err_cnt++;
            $display("FAIL reset_init: got dout=%0h vld=%0b trk=%0d busy=%0b done=%0b err=%0b required all 0",
                     enc_dout, enc_dout_vld, track_cnt, gen_busy, gen_done, cfg_err);
        end
        tick(2);
        sys_rst_n = 1'b1;
        set_cfg(0, 100, 150, 1, 34'd3, 0);
        gen_en = 1'b1;
        tick(6);
        vec_cnt++;
        if (gen_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_pre_busy: got %0b required 1", gen_busy);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({enc_dout, enc_dout_vld, track_cnt, gen_busy, gen_done, cfg_err} !== '0) begin
            err_cnt++;
            $display("FAIL reset_async: got dout=%0h vld=%0b trk=%0d busy=%0b done=%0b err=%0b required all 0",
                     enc_dout, enc_dout_vld, track_cnt, gen_busy, gen_done, cfg_err);
        end
        gen_en = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        tick(1);
        obs_q.delete();
    endtask

    task automatic test_basic();
        int          start_cyc;
        int          n;
        int          prev;
        logic [63:0] last;
        int          i;
        obs_q.delete();
        exp_q.delete();
        set_cfg(0, 100, 1000, 4, 34'd5, 2);
        model(0, 100, 1000, 34'd5, 2, 100);
        start_cyc = cyc;
        gen_en = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        vec_cnt++;
        if (gen_busy !== 1'b1 || enc_dout_vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_load: got busy=%0b vld=%0b required busy=1 vld=0", gen_busy, enc_dout_vld);
        end
        for (i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (gen_done === 1'b1) break;
        end
        vec_cnt++;
        if (i == 300) begin
            err_cnt++;
            $display("FAIL basic_done_timeout: got gen_done=%0b required 1", gen_done);
        end
        tick(6);
        vec_cnt++;
        if (obs_q.size() != 21) begin
            err_cnt++;
            $display("FAIL basic_count: got %0d strobes required 21", obs_q.size());
        end
        n = 0;
        prev = 0;
        last = '0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            obs_t o;
            logic [63:0] e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            last = e;
            vec_cnt++;
            if (o.word !== e) begin
                err_cnt++;
                $display("FAIL basic_word[%0d]: got %0h required %0h", n, o.word, e);
            end
            vec_cnt++;
            if ((n == 0 && o.cyc != start_cyc + 2) || (n != 0 && o.cyc - prev != 4)) begin
                err_cnt++;
                $display("FAIL basic_spacing[%0d]: got cycle %0d previous %0d start %0d", n, o.cyc, prev, start_cyc);
            end
            prev = o.cyc;
            n++;
        end
        vec_cnt++;
        if (track_cnt !== 16'd2 || gen_done !== 1'b1 || gen_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_final: got trk=%0d done=%0b busy=%0b required trk=2 done=1 busy=0",
                     track_cnt, gen_done, gen_busy);
        end
        vec_cnt++;
        if (enc_dout !== last || last[33:0] !== 34'd10) begin
            err_cnt++;
            $display("FAIL basic_hold: got %0h required %0h with lin 10", enc_dout, last);
        end
        gen_en = 1'b0;
        tick(2);
        vec_cnt++;
        if (gen_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_idle: got gen_done=%0b required 0", gen_done);
        end
    endtask

    task automatic test_wrap_remainder();
        obs_q.delete();
        exp_q.delete();
        set_cfg(950, 100, 1000, 2, 34'd7, 0);
        model(950, 100, 1000, 34'd7, 0, 3);
        gen_en = 1'b1;
        wait_strobes(3, 50, "wrap");
        gen_en = 1'b0;
        tick(3);
        for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
            obs_t o;
            logic [63:0] e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            vec_cnt++;
            if (o.word !== e) begin
                err_cnt++;
                $display("FAIL wrap_word[%0d]: got %0h required %0h", k, o.word, e);
            end
            if (k == 1) begin
                vec_cnt++;
                if (o.word[51:34] !== 18'd50 || o.trk !== 16'd1) begin
                    err_cnt++;
                    $display("FAIL wrap_second: got angle=%0d trk=%0d required angle=50 trk=1", o.word[51:34], o.trk);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_illegal_cfg();
        int tbl[3][3] = '{'{0, 10, 0}, '{0, 1000, 1000}, '{1000, 10, 1000}};
        obs_q.delete();
        for (int k = 0; k < 3; k++) begin
            set_cfg(tbl[k][0], tbl[k][1], tbl[k][2], 1, 34'd1, 0);
            gen_en = 1'b1;
            tick(4);
            vec_cnt++;
            if (cfg_err !== 1'b1 || gen_done !== 1'b1 || gen_busy !== 1'b0 || obs_q.size() != 0) begin
                err_cnt++;
                $display("FAIL illegal[%0d]: got err=%0b done=%0b busy=%0b strobes=%0d required 1 1 0 0",
                         k, cfg_err, gen_done, gen_busy, obs_q.size());
            end
            gen_en = 1'b0;
            tick(2);
            vec_cnt++;
            if (cfg_err !== 1'b1 || gen_done !== 1'b0) begin
                err_cnt++;
                $display("FAIL illegal_sticky[%0d]: got err=%0b done=%0b required err=1 done=0", k, cfg_err, gen_done);
            end
        end
        set_cfg(0, 10, 1000, 5, 34'd1, 0);
        gen_en = 1'b1;
        tick(3);
        vec_cnt++;
        if (cfg_err !== 1'b0 || gen_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL illegal_clear: got err=%0b busy=%0b required err=0 busy=1", cfg_err, gen_busy);
        end
        gen_en = 1'b0;
        tick(3);
        obs_q.delete();
    endtask

    task automatic test_mid_stop();
        logic [63:0] last;
        obs_q.delete();
        exp_q.delete();
        set_cfg(5, 20, 100, 1, 34'd3, 0);
        model(5, 20, 100, 34'd3, 0, 3);
        last = exp_q[2];
        gen_en = 1'b1;
        wait_strobes(3, 50, "stop");
        gen_en = 1'b0;
        tick(1);
        vec_cnt++;
        if (gen_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL stop_idle: got busy=%0b required 0", gen_busy);
        end
        tick(4);
        vec_cnt++;
        if (obs_q.size() != 3) begin
            err_cnt++;
            $display("FAIL stop_count: got %0d strobes required 3", obs_q.size());
        end
        vec_cnt++;
        if (enc_dout !== last) begin
            err_cnt++;
            $display("FAIL stop_hold: got %0h required %0h", enc_dout, last);
        end
        for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
            obs_t o;
            logic [63:0] e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            vec_cnt++;
            if (o.word !== e) begin
                err_cnt++;
                $display("FAIL stop_word[%0d]: got %0h required %0h", k, o.word, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_soft_reset();
        int n;
        int prev;
        obs_q.delete();
        exp_q.delete();
        set_cfg(0, 7, 20, 0, 34'd9, 0);
        model(0, 7, 20, 34'd9, 0, 50);
        gen_en = 1'b1;
        wait_strobes(5, 50, "soft");
        soft_rst_sync = 1'b1;
        @(posedge sys_clk);
        #1;
        soft_rst_sync = 1'b0;
        gen_en = 1'b0;
        vec_cnt++;
        if ({enc_dout, enc_dout_vld, track_cnt, gen_busy, gen_done, cfg_err} !== '0) begin
            err_cnt++;
            $display("FAIL soft_outputs: got dout=%0h vld=%0b trk=%0d busy=%0b done=%0b err=%0b required all 0",
                     enc_dout, enc_dout_vld, track_cnt, gen_busy, gen_done, cfg_err);
        end
        n = obs_q.size();
        tick(3);
        vec_cnt++;
        if (obs_q.size() != n || gen_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL soft_idle: got strobes %0d busy=%0b required %0d busy=0", obs_q.size(), gen_busy, n);
        end
        prev = 0;
        for (int k = 0; obs_q.size() > 0; k++) begin
            obs_t o;
            logic [63:0] e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            vec_cnt++;
            if (o.word !== e || (k != 0 && o.cyc - prev != 1)) begin
                err_cnt++;
                $display("FAIL soft_word[%0d]: got %0h at cycle %0d required %0h one cycle after %0d",
                         k, o.word, o.cyc, e, prev);
            end
            prev = o.cyc;
        end
        exp_q.delete();
    endtask

    task automatic test_jitter();
        int d;
        for (int r = 0; r < 2; r++) begin
            obs_q.delete();
            set_cfg(0, 10, 1000, 1, 34'd0, 0);
            gen_en = 1'b1;
            wait_strobes(40, 100, "jitter");
            gen_en = 1'b0;
            tick(3);
            for (int k = 0; k < 40; k++) begin
                if (obs_q.size() > 0) begin
                    obs_t o;
                    o = obs_q.pop_front();
                    jit_a[r][k] = int'(o.word[51:34]);
                end else begin
                    jit_a[r][k] = -1;
                end
            end
        end
        for (int k = 1; k < 40; k++) begin
            d = (jit_a[0][k] - jit_a[0][k-1] + 1000) % 1000;
            vec_cnt++;
`ifdef ENC_GEN_JITTER_EN
            if (d != 10 && d != 11) begin
`else
            if (d != 10) begin
`endif
                err_cnt++;
                $display("FAIL jitter_delta[%0d]: got %0d from %0d to %0d", k, d, jit_a[0][k-1], jit_a[0][k]);
            end
        end
        for (int k = 0; k < 40; k++) begin
            vec_cnt++;
            if (jit_a[1][k] != jit_a[0][k] || jit_a[0][k] < 0) begin
                err_cnt++;
                $display("FAIL jitter_repeat[%0d]: got %0d required %0d", k, jit_a[1][k], jit_a[0][k]);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_remainder();
        test_illegal_cfg();
        test_mid_stop();
        test_soft_reset();
        test_jitter();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
